// File: rtl/stage_mem_lsu.sv
// Memory stage: bus handshake with byte lanes, load extraction, optional
// two-beat split of word-crossing accesses, and a writeback register that
// holds its value across wb_stall.
module stage_mem_lsu #(
   parameter int XLEN             = 32,
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mem_valid,
   input  logic [XLEN-1:0]   mem_pc,
   input  logic [XLEN-1:0]   mem_data0,
   input  logic [XLEN-1:0]   mem_data1,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_extend,
   input  logic [1:0]        mem_width,
   input  logic              mem_jmp,
   input  logic              mem_br,
   input  logic              mem_br_inv,
   input  logic [4:0]        wb_reg,
   input  logic              wb_stall,
   output logic              req,
   output logic [XLEN-1:0]   addr,
   output logic              we,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN/8-1:0] be,
   input  logic              ack,
   input  logic [XLEN-1:0]   rdata,
   output logic              mem_wen,
   output logic              fe_enable,
   output logic              pc_wen,
   output logic [XLEN-1:0]   pc,
   output logic              mem_stall,
   output logic              wb_valid,
   output logic              wb_fault,
   output logic [XLEN-1:0]   wb_pc,
   output logic [4:0]        wb_reg_r,
   output logic [XLEN-1:0]   wb_data
);

   localparam int NB   = XLEN / 8;
   localparam int NB2  = 2 * NB;
   localparam int OFFW = $clog2(NB);
   localparam int SHW  = OFFW + 4;

   typedef enum logic [1:0] {
      BEAT0 = 2'd0,
      BEAT1 = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_rdata0;
   logic [XLEN-1:0] r_pend;

   logic            w_memOp;
   logic [OFFW-1:0] w_off;
   logic [4:0]      w_sz;
   logic            w_illegal;
   logic            w_cross;
   logic            w_fault;
   logic [NB2-1:0]  w_mask;
   logic [NB2-1:0]  w_beWide;
   logic [2*XLEN-1:0] w_wdWide;
   logic [XLEN-1:0] w_addrBase;
   logic [SHW-1:0]  w_sh;
   logic [SHW-1:0]  w_shInv;
   logic [XLEN-1:0] w_rdLo;
   logic [XLEN-1:0] w_rdAlign;
   logic [XLEN-1:0] w_keep;
   logic            w_sign;
   logic [XLEN-1:0] w_loadData;
   logic [XLEN-1:0] w_result;
   logic            w_ackOk;
   logic            w_complete;
   logic            w_direct;
   logic            w_retire;

   // Access geometry: lane offset, size, word crossing and fault detection
   assign w_memOp    = mem_read | mem_write;
   assign w_off      = mem_data0[OFFW-1:0];
   assign w_sz       = 5'd1 << mem_width;
   assign w_illegal  = (XLEN == 32) && (mem_width == 2'd3);
   assign w_cross    = (5'(w_off) + w_sz) > 5'(NB);
   assign w_fault    = w_memOp & (w_illegal | (w_cross & (SPLIT_MISALIGNED == 1'b0)));

   // The low half of each wide vector is beat 0, the high half is beat 1
   assign w_mask     = (NB2'(1) << w_sz) - NB2'(1);
   assign w_beWide   = w_mask << w_off;
   assign w_wdWide   = {{XLEN{1'b0}}, mem_data1} << {w_off, 3'b000};
   assign w_addrBase = {mem_data0[XLEN-1:OFFW], {OFFW{1'b0}}};

   // Bus outputs; req is dropped immediately by reset and never raised in HOLD
   assign req   = reset_n & (((r_state == BEAT0) & mem_valid & w_memOp & ~w_fault) |
                             (r_state == BEAT1));
   assign addr  = (r_state == BEAT1) ? (w_addrBase + XLEN'(NB)) : w_addrBase;
   assign we    = mem_write;
   assign be    = (r_state == BEAT1) ? w_beWide[NB2-1:NB] : w_beWide[NB-1:0];
   assign wdata = (r_state == BEAT1) ? w_wdWide[2*XLEN-1:XLEN] : w_wdWide[XLEN-1:0];

   // Load alignment: beat-0 bytes shifted down, beat-1 bytes shifted up on top
   assign w_sh      = SHW'({w_off, 3'b000});
   assign w_shInv   = SHW'(XLEN) - w_sh;
   assign w_rdLo    = (r_state == BEAT1) ? r_rdata0 : rdata;
   assign w_rdAlign = (w_rdLo >> w_sh) | (rdata << w_shInv);

   // Size mask and sign bit of the aligned load value
   always_comb begin
      w_keep = '1;
      w_sign = w_rdAlign[XLEN-1];
      case (mem_width)
         2'd0: begin
            w_keep = XLEN'(8'hFF);
            w_sign = w_rdAlign[7];
         end
         2'd1: begin
            w_keep = XLEN'(16'hFFFF);
            w_sign = w_rdAlign[15];
         end
         2'd2: begin
            w_keep = XLEN'(32'hFFFF_FFFF);
            w_sign = w_rdAlign[31];
         end
         default: begin
            w_keep = '1;
            w_sign = w_rdAlign[XLEN-1];
         end
      endcase
   end

   assign w_loadData = (w_rdAlign & w_keep) | ((mem_extend & w_sign) ? ~w_keep : '0);
   assign w_result   = (w_memOp & ~w_fault & mem_read) ? w_loadData : mem_data0;

   // Retire control: bus completion, bus-free ops, or release from HOLD
   assign w_ackOk    = req & ack;
   assign w_complete = w_ackOk & (((r_state == BEAT0) & ~w_cross) | (r_state == BEAT1));
   assign w_direct   = reset_n & (r_state == BEAT0) & mem_valid & (~w_memOp | w_fault);
   assign w_retire   = ~wb_stall & (w_direct | w_complete | (reset_n & (r_state == HOLD)));

   assign mem_stall = reset_n & mem_valid & ~w_retire;
   assign fe_enable = w_retire & (mem_jmp | mem_br);
   assign pc_wen    = w_retire & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
   assign pc        = mem_data1;
   assign mem_wen   = mem_valid & ~mem_read & ~mem_write & (wb_reg != 5'd0);

   // Access FSM plus the writeback result register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= BEAT0;
         r_rdata0 <= '0;
         r_pend   <= '0;
         wb_valid <= 1'b0;
         wb_fault <= 1'b0;
         wb_pc    <= '0;
         wb_reg_r <= '0;
         wb_data  <= '0;
      end else begin
         case (r_state)
            BEAT0: begin
               if (w_ackOk && w_cross) begin
                  r_rdata0 <= rdata;
                  r_state  <= BEAT1;
               end else if (w_complete && wb_stall) begin
                  r_pend  <= w_result;
                  r_state <= HOLD;
               end
            end
            BEAT1: begin
               if (w_complete) begin
                  if (wb_stall) begin
                     r_pend  <= w_result;
                     r_state <= HOLD;
                  end else begin
                     r_state <= BEAT0;
                  end
               end
            end
            HOLD: begin
               if (!wb_stall) r_state <= BEAT0;
            end
            default: r_state <= BEAT0;
         endcase

         if (w_retire) begin
            wb_valid <= 1'b1;
            wb_fault <= w_fault & (r_state == BEAT0);
            wb_pc    <= mem_pc;
            wb_reg_r <= wb_reg;
            wb_data  <= (r_state == HOLD) ? r_pend : w_result;
         end else if (!wb_stall) begin
            wb_valid <= 1'b0;
            wb_fault <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Testbench for stage_mem_lsu (XLEN=32): a split-enabled instance carries the
// main traffic, a split-disabled instance covers the misaligned fault path.
module tb_stage_mem_lsu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_valid, mvNs;
   logic [31:0] mem_pc, mem_data0, mem_data1;
   logic        mem_read, mem_write, mem_extend;
   logic [1:0]  mem_width;
   logic        mem_jmp, mem_br, mem_br_inv;
   logic [4:0]  wb_reg;
   logic        wb_stall;
   logic        ack, ackNs;
   logic [31:0] rdata;

   logic        req, we, mem_wen, fe_enable, pc_wen, mem_stall, wb_valid, wb_fault;
   logic [31:0] addr, wdata, pc, wb_pc, wb_data;
   logic [3:0]  be;
   logic [4:0]  wb_reg_r;

   logic        reqNs, weNs, memWenNs, feNs, pcWenNs, memStallNs, wbValidNs, wbFaultNs;
   logic [31:0] addrNs, wdataNs, pcNs, wbPcNs, wbDataNs;
   logic [3:0]  beNs;
   logic [4:0]  wbRegNs;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        fault;
   } ret_t;

   ret_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic stallAtEdge = 1'b0;

   // Free-running clock
   always #5 clk = ~clk;

   stage_mem_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_pc(mem_pc),
      .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_read(mem_read),
      .mem_write(mem_write), .mem_extend(mem_extend), .mem_width(mem_width),
      .mem_jmp(mem_jmp), .mem_br(mem_br), .mem_br_inv(mem_br_inv), .wb_reg(wb_reg),
      .wb_stall(wb_stall), .req(req), .addr(addr), .we(we), .wdata(wdata), .be(be),
      .ack(ack), .rdata(rdata), .mem_wen(mem_wen), .fe_enable(fe_enable),
      .pc_wen(pc_wen), .pc(pc), .mem_stall(mem_stall), .wb_valid(wb_valid),
      .wb_fault(wb_fault), .wb_pc(wb_pc), .wb_reg_r(wb_reg_r), .wb_data(wb_data)
   );

   stage_mem_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dutNs (
      .clk(clk), .reset_n(reset_n), .mem_valid(mvNs), .mem_pc(mem_pc),
      .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_read(mem_read),
      .mem_write(mem_write), .mem_extend(mem_extend), .mem_width(mem_width),
      .mem_jmp(mem_jmp), .mem_br(mem_br), .mem_br_inv(mem_br_inv), .wb_reg(wb_reg),
      .wb_stall(wb_stall), .req(reqNs), .addr(addrNs), .we(weNs), .wdata(wdataNs),
      .be(beNs), .ack(ackNs), .rdata(rdata), .mem_wen(memWenNs), .fe_enable(feNs),
      .pc_wen(pcWenNs), .pc(pcNs), .mem_stall(memStallNs), .wb_valid(wbValidNs),
      .wb_fault(wbFaultNs), .wb_pc(wbPcNs), .wb_reg_r(wbRegNs), .wb_data(wbDataNs)
   );

   // Single comparison point: counts every vector and reports miscompares
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive the instruction fields (mem_valid is handled by the caller)
   task automatic applyStimulus(input logic [31:0] ipc, d0, d1, input logic rd, wr, ext,
                                input logic [1:0] width, input logic jmp, br, inv,
                                input logic [4:0] rg);
      mem_pc     = ipc;
      mem_data0  = d0;
      mem_data1  = d1;
      mem_read   = rd;
      mem_write  = wr;
      mem_extend = ext;
      mem_width  = width;
      mem_jmp    = jmp;
      mem_br     = br;
      mem_br_inv = inv;
      wb_reg     = rg;
   endtask

   task automatic idleInputs();
      mem_valid = 1'b0;
      mvNs      = 1'b0;
      applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   // Bus access with a bench-side responder; expected retire pushed at issue
   task automatic doAccess(input string tag, input logic [31:0] ipc, d0, d1,
                           input logic rd, wr, ext, input logic [1:0] width, input int beats,
                           input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0, r0,
                           input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1, r1,
                           input int ackDelay, input logic [31:0] expData);
      @(posedge clk); #1;
      applyStimulus(ipc, d0, d1, rd, wr, ext, width, 1'b0, 1'b0, 1'b0, 5'd7);
      mem_valid = 1'b1;
      sb.push_back('{ipc, 5'd7, expData, 1'b0});
      for (int b = 0; b < beats; b++) begin
         int n = 0;
         @(negedge clk);
         while (!req && n < 8) begin
            @(negedge clk);
            n++;
         end
         if (!req) begin
            checkOutput({tag, "_reqTimeout"}, 32'(req), 32'd1);
            idleInputs();
            return;
         end
         checkOutput({tag, "_addr"}, addr, (b == 0) ? a0 : a1);
         checkOutput({tag, "_be"}, 32'(be), 32'((b == 0) ? b0 : b1));
         checkOutput({tag, "_we"}, 32'(we), 32'(wr));
         if (wr) checkOutput({tag, "_wdata"}, wdata, (b == 0) ? w0 : w1);
         if (b == 0 && ackDelay > 0) begin
            repeat (ackDelay) @(negedge clk);
            checkOutput({tag, "_reqHeld"}, 32'(req), 32'd1);
            checkOutput({tag, "_addrHeld"}, addr, a0);
            if (wr) checkOutput({tag, "_wdataHeld"}, wdata, w0);
         end
         ack   = 1'b1;
         rdata = (b == 0) ? r0 : r1;
         @(posedge clk); #1;
         ack = 1'b0;
      end
      idleInputs();
   endtask

   // Bus-free op: checks redirect outputs in the issue cycle
   task automatic doAlu(input string tag, input logic [31:0] ipc, d0, d1,
                        input logic jmp, br, inv, input logic [4:0] rg,
                        input logic expPcWen, expFe);
      @(posedge clk); #1;
      applyStimulus(ipc, d0, d1, 1'b0, 1'b0, 1'b0, 2'd2, jmp, br, inv, rg);
      mem_valid = 1'b1;
      sb.push_back('{ipc, rg, d0, 1'b0});
      @(negedge clk);
      checkOutput({tag, "_memStall"}, 32'(mem_stall), 32'd0);
      checkOutput({tag, "_pcWen"}, 32'(pc_wen), 32'(expPcWen));
      checkOutput({tag, "_feEnable"}, 32'(fe_enable), 32'(expFe));
      checkOutput({tag, "_memWen"}, 32'(mem_wen), 32'(rg != 5'd0));
      if (expPcWen) checkOutput({tag, "_pc"}, pc, d1);
      @(posedge clk); #1;
      idleInputs();
   endtask

   // Scoreboard monitor: a fresh retirement shows up after an unstalled edge
   always @(posedge clk) stallAtEdge <= wb_stall;

   always @(negedge clk) begin
      if (reset_n && wb_valid && !stallAtEdge) begin
         if (sb.size() == 0) begin
            checkOutput("sbUnexpectedRetire", 32'(wb_valid), 32'd0);
         end else begin
            ret_t e;
            e = sb.pop_front();
            checkOutput("wbPc", wb_pc, e.pc);
            checkOutput("wbReg", 32'(wb_reg_r), 32'(e.rd));
            checkOutput("wbData", wb_data, e.data);
            checkOutput("wbFault", 32'(wb_fault), 32'(e.fault));
         end
      end
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      int pulses;
      reset_n  = 1'b0;
      wb_stall = 1'b0;
      ack      = 1'b0;
      ackNs    = 1'b0;
      rdata    = '0;
      idleInputs();
      mem_valid = 1'b1;
      mem_read  = 1'b1;
      mem_jmp   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstReq", 32'(req), 32'd0);
      checkOutput("rstMemStall", 32'(mem_stall), 32'd0);
      checkOutput("rstPcWen", 32'(pc_wen), 32'd0);
      checkOutput("rstFeEnable", 32'(fe_enable), 32'd0);
      @(posedge clk); #1;
      idleInputs();
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rstWbValid", 32'(wb_valid), 32'd0);
      checkOutput("rstWbFault", 32'(wb_fault), 32'd0);
      checkOutput("rstWbData", wb_data, 32'd0);
      checkOutput("rstWbPc", wb_pc, 32'd0);
      checkOutput("rstWbReg", 32'(wb_reg_r), 32'd0);

      $display("[TB] aligned and extended loads, stores");
      doAccess("lw", 32'h40, 32'h100, 32'h0, 1, 0, 0, 2'd2, 1,
               32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 32'h0, 0, 32'hDEADBEEF);
      doAccess("lb", 32'h44, 32'h103, 32'h0, 1, 0, 1, 2'd0, 1,
               32'h100, 4'h8, 32'h0, 32'h80123456, 32'h0, 4'h0, 32'h0, 32'h0, 0, 32'hFFFFFF80);
      doAccess("lbu", 32'h48, 32'h103, 32'h0, 1, 0, 0, 2'd0, 1,
               32'h100, 4'h8, 32'h0, 32'h80123456, 32'h0, 4'h0, 32'h0, 32'h0, 0, 32'h00000080);
      doAccess("sh", 32'h4C, 32'h102, 32'h1234, 0, 1, 0, 2'd1, 1,
               32'h100, 4'hC, 32'h12340000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 32'h102);
      doAccess("lh", 32'h50, 32'h102, 32'h0, 1, 0, 1, 2'd1, 1,
               32'h100, 4'hC, 32'h0, 32'hF00D1234, 32'h0, 4'h0, 32'h0, 32'h0, 0, 32'hFFFFF00D);
      doAccess("swDelay", 32'h54, 32'h104, 32'h0BADF00D, 0, 1, 0, 2'd2, 1,
               32'h104, 4'hF, 32'h0BADF00D, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 2, 32'h104);

      $display("[TB] split accesses");
      doAccess("lwSplit", 32'h58, 32'h102, 32'h0, 1, 0, 0, 2'd2, 2,
               32'h100, 4'hC, 32'h0, 32'h5566AAAA, 32'h104, 4'h3, 32'h0, 32'hBBBB7788, 0, 32'h77885566);
      doAccess("swSplit", 32'h5C, 32'h102, 32'hAABBCCDD, 0, 1, 0, 2'd2, 2,
               32'h100, 4'hC, 32'hCCDD0000, 32'h0, 32'h104, 4'h3, 32'h0000AABB, 32'h0, 1, 32'h102);
      doAccess("lhuSplit", 32'h60, 32'h1FF, 32'h0, 1, 0, 0, 2'd1, 2,
               32'h1FC, 4'h8, 32'h0, 32'hAB000000, 32'h200, 4'h1, 32'h0, 32'h000000CD, 0, 32'h0000CDAB);

      $display("[TB] non-memory ops and redirects");
      doAlu("alu", 32'h64, 32'h12345678, 32'h0, 0, 0, 0, 5'd3, 0, 0);
      doAlu("jmp", 32'h68, 32'h0000006C, 32'h300, 1, 0, 0, 5'd1, 1, 1);
      doAlu("brNotTaken", 32'h6C, 32'h1, 32'h400, 0, 1, 1, 5'd0, 0, 1);
      doAlu("brTaken", 32'h70, 32'h0, 32'h500, 0, 1, 1, 5'd0, 1, 1);

      $display("[TB] faults");
      @(posedge clk); #1;
      applyStimulus(32'h74, 32'h108, 32'h0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 5'd9);
      mem_valid = 1'b1;
      sb.push_back('{32'h74, 5'd9, 32'h108, 1'b1});
      @(negedge clk);
      checkOutput("ldIllegalReq", 32'(req), 32'd0);
      @(posedge clk); #1;
      idleInputs();

      @(posedge clk); #1;
      applyStimulus(32'h78, 32'h102, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 5'd4);
      mvNs = 1'b1;
      @(negedge clk);
      checkOutput("nsReq", 32'(reqNs), 32'd0);
      checkOutput("nsMemStall", 32'(memStallNs), 32'd0);
      @(posedge clk); #1;
      idleInputs();
      @(negedge clk);
      checkOutput("nsReqAfter", 32'(reqNs), 32'd0);
      checkOutput("nsWbValid", 32'(wbValidNs), 32'd1);
      checkOutput("nsWbFault", 32'(wbFaultNs), 32'd1);
      checkOutput("nsWbData", wbDataNs, 32'h102);

      $display("[TB] writeback stall");
      @(posedge clk); #1;
      applyStimulus(32'h80, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 5'd7);
      mem_valid = 1'b1;
      wb_stall  = 1'b1;
      ack       = 1'b1;
      rdata     = 32'h11223344;
      sb.push_back('{32'h80, 5'd7, 32'h11223344, 1'b0});
      @(negedge clk);
      checkOutput("stallReq", 32'(req), 32'd1);
      checkOutput("stallMemStall0", 32'(mem_stall), 32'd1);
      @(posedge clk); #1;
      ack   = 1'b0;
      rdata = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("holdReq", 32'(req), 32'd0);
         checkOutput("holdMemStall", 32'(mem_stall), 32'd1);
         checkOutput("holdWbValid", 32'(wb_valid), 32'd0);
         @(posedge clk); #1;
      end
      wb_stall = 1'b0;
      @(negedge clk);
      checkOutput("holdRelease", 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      idleInputs();

      @(posedge clk); #1;
      applyStimulus(32'h84, 32'h1, 32'h200, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 5'd0);
      mem_valid = 1'b1;
      wb_stall  = 1'b1;
      pulses    = 0;
      sb.push_back('{32'h84, 5'd0, 32'h1, 1'b0});
      @(negedge clk);
      pulses += int'(pc_wen);
      @(posedge clk); #1;
      @(negedge clk);
      pulses += int'(pc_wen);
      @(posedge clk); #1;
      wb_stall = 1'b0;
      @(negedge clk);
      pulses += int'(pc_wen);
      checkOutput("brStallPc", pc, 32'h200);
      checkOutput("brStallFe", 32'(fe_enable), 32'd1);
      @(posedge clk); #1;
      idleInputs();
      @(negedge clk);
      pulses += int'(pc_wen);
      checkOutput("brStallPulses", 32'(pulses), 32'd1);

      $display("[TB] reset during second beat");
      @(posedge clk); #1;
      applyStimulus(32'h90, 32'h102, 32'h0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 5'd7);
      mem_valid = 1'b1;
      @(negedge clk);
      checkOutput("rstB0Req", 32'(req), 32'd1);
      ack   = 1'b1;
      rdata = 32'h12345678;
      @(posedge clk); #1;
      ack = 1'b0;
      @(negedge clk);
      checkOutput("rstB1Req", 32'(req), 32'd1);
      checkOutput("rstB1Addr", addr, 32'h104);
      @(posedge clk); #1;
      reset_n = 1'b0;
      idleInputs();
      @(negedge clk);
      checkOutput("rstMidReq", 32'(req), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rstMidIdleReq", 32'(req), 32'd0);
      checkOutput("rstMidWbValid", 32'(wb_valid), 32'd0);
      doAccess("lwAfterRst", 32'h94, 32'h100, 32'h0, 1, 0, 0, 2'd2, 1,
               32'h100, 4'hF, 32'h0, 32'hCAFEF00D, 32'h0, 4'h0, 32'h0, 32'h0, 0, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("sbDrained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stage_mem_lsu.md
# stage_mem_lsu

Parametrised successor memory stage for the in-order pipeline, between execute and writeback. Adds a multi-cycle bus handshake with byte enables and lane alignment, internal load extraction with sign or zero extension, and optional splitting of word-crossing accesses into two bus beats. Also adds a registered writeback result held across `wb_stall`, and branch redirects issued exactly once per instruction. XLEN is 32 or 64.

## Interface
- XLEN, 32, datapath/address width (32 or 64); NB = XLEN/8 bytes per bus word
- SPLIT_MISALIGNED, 1, 1: crossing accesses split into two beats; 0: crossing accesses fault with no bus request
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- mem_valid  in  1  instruction present; execute holds all inputs stable while mem_stall=1
- mem_pc  in  XLEN  instruction PC
- mem_data0  in  XLEN  effective address (mem op) / ALU result; bit0 = branch condition
- mem_data1  in  XLEN  store data / branch target
- mem_read, mem_write  in  1 each  load / store
- mem_extend  in  1  sign-extend load
- mem_width  in  2  size 1<<mem_width bytes (0=B, 1=H, 2=W, 3=D; 3 legal only for XLEN=64)
- mem_jmp, mem_br, mem_br_inv  in  1 each  jump / branch / invert condition
- wb_reg  in  5  destination register
- wb_stall  in  1  writeback cannot accept
- req  out  1  bus request
- addr  out  XLEN  NB-aligned bus address
- we  out  1  write
- wdata  out  XLEN  lane-shifted store data
- be  out  NB  byte enables
- ack  in  1  single-cycle completion; may arrive in the same cycle as req
- rdata  in  XLEN  read data, valid with ack
- mem_wen  out  1  forwarding valid: mem_valid & ~mem_read & ~mem_write & wb_reg!=0
- fe_enable, pc_wen  out  1 each  fetch redirect control
- pc  out  XLEN  redirect target (= mem_data1)
- mem_stall  out  1  hold execute
- wb_valid, wb_fault  out  1 each  registered result valid / access fault
- wb_pc  out  XLEN;  wb_reg_r  out  5;  wb_data  out  XLEN  registered writeback fields

## Operation
- off = addr[log2(NB)-1:0], sz = 1<<mem_width, cross = off+sz > NB. fault = mem op & (illegal width | (cross & SPLIT_MISALIGNED==0)).
- FSM states: BEAT0 (reset/idle), BEAT1, HOLD.
- BEAT0: req = reset_n & mem_valid & mem op & ~fault.
  - Bus fields: addr = mem_data0 & ~(NB-1); be = ((1<<sz)-1)<<off, truncated to NB bits; wdata = mem_data1<<(8*off).
  - On ack with cross: capture rdata, go to BEAT1.
  - On ack without cross: complete.
- BEAT1: req=1; addr = beat0 addr+NB; be = ((1<<sz)-1)>>(NB-off); wdata = mem_data1>>(8*(NB-off)). On ack: complete.
- Load assembly: (beat0 rdata>>8*off) | (beat1 rdata<<8*(NB-off)), masked to sz bytes, then sign-extended if mem_extend, else zero-extended. Stores and non-mem ops: result = mem_data0.
- Complete:
  - wb_stall=0: retire, return to BEAT0.
  - wb_stall=1: latch the result into a pending register, go to HOLD, and issue no further req.
- HOLD: retire when wb_stall=0, then go to BEAT0.
- Non-mem op or faulting op: retires from BEAT0 in any cycle with wb_stall=0; no bus activity.
- Retire: register wb_valid=1, wb_pc, wb_reg_r, wb_data, and wb_fault=fault. A faulting op has wb_data=mem_data0.
- wb_stall=1: all wb_* outputs hold. wb_stall=0 with no retire: wb_valid<=0, wb_fault<=0.
- mem_stall = reset_n & mem_valid & ~retire.
- fe_enable = retire & (mem_jmp|mem_br).
- pc_wen = retire & (mem_jmp | (mem_br & (mem_data0[0]^mem_br_inv))). Exactly one pulse per instruction.

## Timing
- Reset: state BEAT0; wb_valid, wb_fault 0; wb_pc, wb_reg_r, wb_data 0; req, pc_wen, fe_enable, mem_stall 0 while reset_n=0.
- Reset mid-transaction abandons it; the bus must tolerate a dropped req.
- Non-mem op: wb_valid the cycle after mem_valid, when wb_stall=0.
- Aligned access: wb_valid the cycle after ack. Split access: wb_valid the cycle after the second ack; minimum 2 cycles.
- req, addr, we, wdata, be stay stable from req assertion until ack.
- ack arriving while req=0 is ignored.

## Test plan
- XLEN=32, lw 0x100, ack same cycle, rdata 0xDEADBEEF -> one req, addr 0x100, be 0xF; next cycle wb_valid=1, wb_data 0xDEADBEEF.
- lb 0x103, rdata 0x80123456 -> be 0x8, wb_data 0xFFFFFF80; lbu -> 0x00000080. sh 0x102, data 0x1234 -> wdata 0x12340000, be 0xC.
- SPLIT=1, lw 0x102: beat0 addr 0x100 be 0xC rdata 0x5566AAAA; beat1 addr 0x104 be 0x3 rdata 0xBBBB7788 -> wb_data 0x77885566. sw 0x102, data 0xAABBCCDD -> beat0 wdata 0xCCDD0000 be 0xC; beat1 wdata 0x0000AABB be 0x3.
- SPLIT=0, lw 0x102 -> req never asserted; next cycle wb_valid=1, wb_fault=1.
- Load acked with wb_stall=1 for 3 cycles -> HOLD, mem_stall=1, no new req, wb_* held; wb_data updates the cycle after wb_stall falls. Taken branch to 0x200 under 2-cycle wb_stall -> a single pc_wen pulse with pc=0x200.
- reset_n low during BEAT1 -> req 0 next cycle, state BEAT0; after release, a fresh lw completes normally.
